// File: rtl/subtractor_nbit_serial.sv
// Bit-serial N-bit subtractor: diff = A - B - borrow_in, one bit per clock, LSB first,
// with a start/busy/done handshake.
module subtractor_nbit_serial #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         borrow_in,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         borrow_out,
  output logic [N-1:0] diff
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic d_bit;
  logic br_next;

  // Full-subtract cell applied to the current LSBs.
  always_comb begin
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_d     = A;
          b_d     = B;
          br_d    = borrow_in;
          cnt_d   = '0;
          diff_d  = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_next;
        // New bit enters at the MSB so bit 0 lands at diff[0] after N shifts.
        diff_d = {d_bit, diff_q[N-1:1]};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
          bout_d  = br_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign borrow_out = bout_q;
  assign diff       = diff_q;

endmodule

// File: tb/tb_subtractor_nbit_serial.sv
// Scoreboard bench for subtractor_nbit_serial at N=8 (directed + random) and N=16 (random).
module tb_subtractor_nbit_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, bin8, busy8, done8, bout8;
  logic [7:0]  a8, b8, diff8;
  logic        start16, bin16, busy16, done16, bout16;
  logic [15:0] a16, b16, diff16;

  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;
  logic [8:0]  q8[$];
  logic [16:0] q16[$];

  subtractor_nbit_serial #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .borrow_in(bin8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .borrow_out(bout8), .diff(diff8)
  );

  subtractor_nbit_serial #(.N(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .borrow_in(bin16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .borrow_out(bout16), .diff(diff16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the scoreboard whenever a DUT presents done.
  always @(negedge clk) begin
    logic [8:0] e;
    if (done8) begin
      done_cnt8++;
      check("busy_at_done8", 32'(busy8), 32'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: got done=1 expected no done");
      end else begin
        e = q8.pop_front();
        check("diff8", 32'(diff8), 32'(e[7:0]));
        check("borrow8", 32'(bout8), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (done16) begin
      check("busy_at_done16", 32'(busy16), 32'd0);
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done16: got done=1 expected no done");
      end else begin
        e = q16.pop_front();
        check("diff16", 32'(diff16), 32'(e[15:0]));
        check("borrow16", 32'(bout16), 32'(e[16]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Call #1 after a rising edge with the DUT idle; returns #1 after the accepting edge.
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                           input logic [7:0] ed, input logic eb);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    q8.push_back({eb, ed});
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic wait_done8(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i - 1;
        return;
      end
      if (busy8) bc++;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb);
    int lat, bc;
    start_op8(a, b, bin, ed, eb);
    wait_done8(lat, bc);
    check("latency8", 32'(lat), 32'd8);
    check("busy_cycles8", 32'(bc), 32'd8);
    @(posedge clk);
    #1;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int unsigned av, bv, ev;
    bit seen;
    av = a; bv = b;
    ev = (av - bv - bin) & 32'hFFFF;
    a16 = a; b16 = b; bin16 = bin; start16 = 1'b1;
    q16.push_back({(av < bv + bin), ev[15:0]});
    @(posedge clk);
    #1 start16 = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 22 && !seen; i++) begin
      @(negedge clk);
      if (done16) begin
        seen = 1'b1;
        check("latency16", 32'(i - 1), 32'd16);
      end
    end
    if (!seen) check("done16_seen", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bb_a[3]  = '{8'h10, 8'h01, 8'hC8};
  logic [7:0] bb_b[3]  = '{8'h01, 8'h02, 8'h64};
  logic       bb_c[3]  = '{1'b0, 1'b0, 1'b1};
  logic [7:0] bb_d[3]  = '{8'h0F, 8'hFF, 8'h63};
  logic       bb_o[3]  = '{1'b0, 1'b1, 1'b0};

  initial begin
    int lat, bc, dc, gap;
    int unsigned ra, rb, rc, re;
    bit seen;
    rst_n = 1'b0; start8 = 1'b0; bin8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; bin16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_borrow", 32'(bout8), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    op8(8'h0A, 8'h03, 1'b0, 8'h07, 1'b0);
    op8(8'h00, 8'h0A, 1'b0, 8'hF6, 1'b1);
    op8(8'h31, 8'h2A, 1'b1, 8'h06, 1'b0);
    op8(8'h0B, 8'h0B, 1'b1, 8'hFF, 1'b1);
    op8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

    // Start re-asserted with new operands mid-run must be ignored.
    dc = done_cnt8;
    start_op8(8'h55, 8'h23, 1'b0, 8'h32, 1'b0);
    repeat (3) @(posedge clk);
    #1 start8 = 1'b1; a8 = 8'h01; b8 = 8'hFF; bin8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8(lat, bc);
    check("midrun_latency", 32'(lat), 32'd4);
    repeat (11) @(posedge clk);
    check("midrun_done_count", 32'(done_cnt8 - dc), 32'd1);
    #1;

    // Reset while the counter sits at bit 4.
    start_op8(8'hAA, 8'h11, 1'b0, 8'h99, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    q8.delete();
    @(negedge clk);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_diff", 32'(diff8), 32'd0);
    check("midrst_borrow", 32'(bout8), 32'd0);
    dc = done_cnt8;
    repeat (12) @(posedge clk);
    check("midrst_no_done", 32'(done_cnt8 - dc), 32'd0);
    #1;
    op8(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0);

    // start held high: one done every 9 cycles.
    a8 = bb_a[0]; b8 = bb_b[0]; bin8 = bb_c[0]; start8 = 1'b1;
    q8.push_back({bb_o[0], bb_d[0]});
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      gap = 0;
      seen = 1'b0;
      for (int c = 1; c <= 14 && !seen; c++) begin
        @(negedge clk);
        gap++;
        if (done8) seen = 1'b1;
      end
      check("b2b_gap", 32'(gap), 32'd9);
      if (i < 2) begin
        a8 = bb_a[i+1]; b8 = bb_b[i+1]; bin8 = bb_c[i+1];
        q8.push_back({bb_o[i+1], bb_d[i+1]});
      end else begin
        start8 = 1'b0;
      end
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 200; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      rc = $urandom_range(0, 1);
      re = (ra - rb - rc) & 32'hFF;
      op8(ra[7:0], rb[7:0], rc[0], re[7:0], (ra < rb + rc));
    end
    for (int i = 0; i < 200; i++) begin
      ra = $urandom_range(0, 65535);
      rb = $urandom_range(0, 65535);
      rc = $urandom_range(0, 1);
      op16(ra[15:0], rb[15:0], rc[0]);
    end

    repeat (3) @(posedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q16_drained", 32'(q16.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
